multi_extreme_pulse: RTL and testbench
======================================

# multi_extreme_pulse

- Collects one W-bit unsigned sample from each of N producers through the shared rfd/dav_ handshake.
- Selects the largest or smallest sample, chosen by `mode`.
- Drives `out` high for exactly that many clock cycles.
- It is the N-channel, width-parametrised, mode-selectable successor of the two-channel 8-bit max/pulse unit, and it handles a zero-length result correctly.

## Interface
- `N`, default 4: number of producer channels (N ≥ 2).
- `W`, default 8: sample and counter width in bits (W ≥ 2).
- `clock`  input  1: single clock; all state changes on its rising edge.
- `reset`  input  1: synchronous, active-high reset, sampled on the rising edge of `clock`.
- `rfd`  output  1: ready-for-data, shared by all producers.
- `dav_`  input  N: data-available per channel, active-low; bit i belongs to channel i.
- `x`  input  N*W: flattened samples; channel i occupies bits [i*W+W-1 : i*W].
- `mode`  input  1: 0 selects maximum, 1 selects minimum. Sampled only at capture.
- `out`  output  1: output pulse.

## Operation
- Reset values:
  - `rfd`=1, `out`=0, state=IDLE.
  - Count register = 0.
  - Reset overrides every other condition, including a pulse in progress.
- Combinational reduction:
  - Unsigned comparator tree over the N samples; the result is the max (mode=0) or min (mode=1).
  - Ties are irrelevant, since only the value is used. No sign extension.
- IDLE:
  - `rfd`=1, `out`=0.
  - If all N `dav_` bits are 0 at an edge: load count ← reduction result (using the current `mode`), then go to RELEASE.
  - If only some `dav_` bits are 0: stay in IDLE and capture nothing.
- RELEASE:
  - `rfd`=0, `out`=0.
  - If all N `dav_` bits are 1 at an edge:
    - count == 0: go to IDLE (no pulse).
    - count ≠ 0: go to PULSE.
  - If only some `dav_` bits are 1: stay in RELEASE.
  - Changes on `x` or `mode` in this state are ignored.
- PULSE:
  - `rfd`=0, `out`=1.
  - On each edge, count ← count − 1.
  - When count == 1 at an edge, go to IDLE.
  - `dav_` is ignored in this state.
- Arithmetic: the count is W bits and never wraps, because PULSE is never entered with count 0.

## Timing
- All outputs are registered; none has a combinational path from the inputs.
- Capture:
  - Let edge E be the edge at which all `dav_`=0 is sampled in IDLE.
  - `rfd` falls after E.
  - `x` and `mode` must be stable in the cycle before E.
- Release: let edge F be the edge at which all `dav_`=1 is sampled in RELEASE.
  - count = R > 0: `out` is 1 for exactly R cycles, starting after F.
    - `out` falls, and `rfd` rises, on the same edge: F+R.
  - count = 0: `rfd` rises after F and `out` never asserts.
- Throughput: minimum transaction length is 2 cycles of handshake plus R cycles of pulse.
- A new capture is possible at the first edge after `rfd` rises.
- Producer rules:
  - A producer asserts `dav_`=0 only while `rfd`=1.
  - It deasserts `dav_` after seeing `rfd`=0.
  - The block does not detect violations of these rules.
- Reset mid-operation:
  - Reset asserted at any edge gives `out`=0, `rfd`=1 and state IDLE after that edge.
  - Any partial count is discarded.
- Reset and a capture condition at the same edge: reset wins and nothing is captured.

## Test plan
Tests 1–5 use N=4, W=8.

1. mode=0, x={3,9,7,1}, all `dav_` fall together, then rise together → `rfd` falls after capture; `out`=1 for exactly 9 cycles after release; `rfd` rises as `out` falls.
2. Same data, mode=1 → `out`=1 for exactly 1 cycle.
3. x={0,0,0,0} with mode=1 → `out` never asserts; `rfd` returns to 1 one cycle after release.
4. Staggered handshake:
   - x={200,5,5,5}, mode=0.
   - `dav_` bits fall on cycles 0, 2, 3 and 6 → no capture before cycle 6.
   - `dav_` bits rise staggered over 4 cycles → PULSE starts only after the last rise.
   - Expected result: a 200-cycle pulse.
5. Reset mid-operation:
   - x={255,0,0,0}, mode=0.
   - Assert `reset` for 1 cycle at pulse cycle 100.
   - Expected: `out`=0 and `rfd`=1 after that edge, no further pulse, and a fresh transaction (x={4,2,2,2}) then gives a 4-cycle pulse.
6. Width boundary: N=2, W=4, x={15,14}, mode=0 → 15-cycle pulse with no count wrap; then mode=1 with x={0,15} → no pulse.

Source files
------------

// File: rtl/multi_extreme_pulse.sv
// N-channel max/min capture over a shared rfd/dav_ handshake,
// followed by an output pulse lasting the selected sample's value in cycles.
module multi_extreme_pulse #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    output logic           rfd,
    input  logic [N-1:0]   dav_,
    input  logic [N*W-1:0] x,
    input  logic           mode,
    output logic           out
);

    typedef enum logic [1:0] {
        IDLE,
        RELEASE,
        PULSE
    } state_t;

    state_t state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] best;
    logic [W-1:0] s;

    // Running unsigned max (mode=0) or min (mode=1) across all channels
    always_comb begin
        best = x[W-1:0];
        s    = '0;
        for (int i = 1; i < N; i++) begin
            s = x[i*W +: W];
            if (mode ? (s < best) : (s > best)) begin
                best = s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (dav_ == '0) begin
                    count_d = best;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (dav_ == '1) begin
                    state_d = (count_q == '0) ? IDLE : PULSE;
                end
            end
            PULSE: begin
                count_d = count_q - W'(1);
                if (count_q == W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rfd     <= 1'b1;
            out     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rfd     <= (state_d == IDLE);
            out     <= (state_d == PULSE);
        end
    end

endmodule

// File: tb/tb_multi_extreme_pulse.sv
// Bench for multi_extreme_pulse: table vectors, corner sequences and
// randomized transactions against a sort-based reference.
module tb_multi_extreme_pulse;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic [3:0]  dav_a  = '1;
    logic [31:0] x_a    = '0;
    logic        mode_a = 1'b0;
    logic        rfd_a, out_a;

    logic [1:0]  dav_b  = '1;
    logic [7:0]  x_b    = '0;
    logic        mode_b = 1'b0;
    logic        rfd_b, out_b;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int xs[4];
        bit m;
        bit sel;
        int exp_len;
    } vec_t;

    vec_t tbl[5];

    always #5 clock = ~clock;

    multi_extreme_pulse #(.N(4), .W(8)) dut_a (
        .clock(clock), .reset(reset), .rfd(rfd_a),
        .dav_(dav_a), .x(x_a), .mode(mode_a), .out(out_a)
    );

    multi_extreme_pulse #(.N(2), .W(4)) dut_b (
        .clock(clock), .reset(reset), .rfd(rfd_b),
        .dav_(dav_b), .x(x_b), .mode(mode_b), .out(out_b)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int model(input int xs[4], input int n, input bit m);
        int q[$];
        for (int i = 0; i < n; i++) q.push_back(xs[i]);
        q.sort();
        return m ? q[0] : q[q.size()-1];
    endfunction

    function automatic logic rfd_m(input bit sel);
        return sel ? rfd_b : rfd_a;
    endfunction

    function automatic logic out_m(input bit sel);
        return sel ? out_b : out_a;
    endfunction

    task automatic set_dav(input bit sel, input bit v);
        if (sel) dav_b = {2{v}};
        else     dav_a = {4{v}};
    endtask

    task automatic load(input bit sel, input int xs[4], input bit m);
        if (sel) begin
            for (int i = 0; i < 2; i++) x_b[i*4 +: 4] = 4'(xs[i]);
            mode_b = m;
        end else begin
            for (int i = 0; i < 4; i++) x_a[i*8 +: 8] = 8'(xs[i]);
            mode_a = m;
        end
    endtask

    // Returns at the negedge following the release edge F
    task automatic capture_release(input bit sel, input int xs[4],
                                   input bit m, input string name);
        @(negedge clock);
        load(sel, xs, m);
        set_dav(sel, 1'b0);
        @(negedge clock);
        check({name, "_rfd_low"}, rfd_m(sel), 1'b0);
        // Scramble data while in RELEASE; must be ignored
        if (sel) begin x_b = 8'($urandom); mode_b = ~m; end
        else     begin x_a = $urandom;     mode_a = ~m; end
        set_dav(sel, 1'b1);
        @(negedge clock);
    endtask

    task automatic measure(input bit sel, input int exp, input string name);
        int len = 0;
        bit rfd_err = 0;
        while (out_m(sel) && len < 400) begin
            if (rfd_m(sel) !== 1'b0) rfd_err = 1;
            len++;
            @(negedge clock);
        end
        check({name, "_len"}, len, exp);
        check({name, "_rfd_back"}, rfd_m(sel), 1'b1);
        check({name, "_rfd_during"}, rfd_err, 0);
    endtask

    task automatic run_txn(input bit sel, input int xs[4], input bit m,
                           input int exp, input string name);
        capture_release(sel, xs, m, name);
        measure(sel, exp, name);
    endtask

    initial begin
        int xs[4];
        int len;
        bit flag;

        tbl[0] = '{'{3, 9, 7, 1},   1'b0, 1'b0, 9};
        tbl[1] = '{'{3, 9, 7, 1},   1'b1, 1'b0, 1};
        tbl[2] = '{'{0, 0, 0, 0},   1'b1, 1'b0, 0};
        tbl[3] = '{'{15, 14, 0, 0}, 1'b0, 1'b1, 15};
        tbl[4] = '{'{0, 15, 0, 0},  1'b1, 1'b1, 0};

        repeat (2) @(negedge clock);
        check("reset_rfd_a", rfd_a, 1'b1);
        check("reset_out_a", out_a, 1'b0);
        check("reset_rfd_b", rfd_b, 1'b1);
        check("reset_out_b", out_b, 1'b0);

        // Reset must win over a simultaneous capture condition
        xs = '{50, 1, 1, 1};
        load(1'b0, xs, 1'b0);
        dav_a = '0;
        @(negedge clock);
        check("reset_vs_capture_rfd", rfd_a, 1'b1);
        dav_a = '1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_rfd", rfd_a, 1'b1);
        check("post_reset_out", out_a, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].sel, tbl[i].xs, tbl[i].m, tbl[i].exp_len,
                    $sformatf("tbl%0d", i));
        end

        // Staggered fall and rise of dav_
        @(negedge clock);
        xs = '{200, 5, 5, 5};
        load(1'b0, xs, 1'b0);
        flag = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) dav_a[0] = 1'b0;
            if (c == 2) dav_a[1] = 1'b0;
            if (c == 3) dav_a[2] = 1'b0;
            if (c == 6) dav_a[3] = 1'b0;
            @(negedge clock);
            if (c < 6 && rfd_a !== 1'b1) flag = 1;
        end
        check("stagger_early_capture", flag, 0);
        check("stagger_rfd_low", rfd_a, 1'b0);
        flag = 0;
        for (int c = 0; c < 4; c++) begin
            dav_a[c] = 1'b1;
            @(negedge clock);
            if (c < 3 && (out_a !== 1'b0 || rfd_a !== 1'b0)) flag = 1;
        end
        check("stagger_early_pulse", flag, 0);
        measure(1'b0, 200, "stagger");

        // Reset in the middle of a long pulse
        xs = '{255, 0, 0, 0};
        capture_release(1'b0, xs, 1'b0, "midreset");
        repeat (99) @(negedge clock);
        check("midreset_out_high", out_a, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_out", out_a, 1'b0);
        check("midreset_rfd", rfd_a, 1'b1);
        len = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (out_a) len++;
        end
        check("midreset_no_pulse", len, 0);
        xs = '{4, 2, 2, 2};
        run_txn(1'b0, xs, 1'b0, 4, "after_reset");

        // Randomized transactions against the sort-based model
        for (int t = 0; t < 20; t++) begin
            bit sel;
            bit m;
            sel = (t >= 12);
            m   = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++)
                xs[i] = sel ? $urandom_range(0, 15) : $urandom_range(0, 60);
            run_txn(sel, xs, m, model(xs, sel ? 2 : 4, m),
                    $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
